row_loader: RTL and testbench

Serial pattern loader that writes externally supplied cell rows into the cellular-automaton frame buffer. It accepts a byte stream over a valid/ready handshake, assembles each group of 13 bytes into one 100-cell row, and writes the row into the frame buffer's write port only while the display grants access (blanking, i.e. `~de`). It replaces the fixed initial pattern with a host-loaded one. In the top level it sits on the frame buffer write-port mux alongside the init and state-machine writers.

---
 rtl/row_loader_if.sv | 29 ++
 rtl/row_loader.sv | 145 ++++++++++++++
 tb/tb_row_loader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/row_loader_if.sv
// row_loader_if: byte-stream and frame-buffer write-port bundle for row_loader.
//   in_valid/in_data/in_sof/in_ready : host byte stream, valid/ready handshake.
//     in_data MSB is the lowest-numbered cell.
//   wr_grant                         : frame buffer write port free (from ~de).
//   wr_en/wr_addr/wr_data            : frame buffer row write port; wr_data[0] is cell 0.
// master = host / frame buffer side, slave = row_loader.
interface row_loader_if #(
  parameter int unsigned COLS   = 100,
  parameter int unsigned ADDR_W = 7
) ();
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_sof;
  logic              in_ready;
  logic              wr_grant;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [0:COLS-1]   wr_data;

  modport master (
    output in_valid, in_data, in_sof, wr_grant,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data, in_sof, wr_grant,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/row_loader.sv
// row_loader: assembles a host byte stream into cell rows and writes each row
// into the frame buffer while the display grants the write port.
// Ports:
//   i_clk          system clock
//   i_rst          synchronous active-low reset
//   io_bus         row_loader_if.slave (byte stream in, row write port out)
//   o_busy         frame load in progress (COLLECT or WAIT_GRANT)
//   o_frame_done   one-cycle pulse after the last row is written
//   o_err          one-cycle pulse on a mid-frame start-of-frame
module row_loader #(
  parameter int unsigned ROWS   = 100,
  parameter int unsigned COLS   = 100,
  parameter int unsigned ADDR_W = 7
) (
  input  logic             i_clk,
  input  logic             i_rst,
  row_loader_if.slave      io_bus,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic             o_err
);

  localparam int unsigned BytesPerRow = (COLS + 7) / 8;
  localparam int unsigned BufW        = BytesPerRow * 8;
  localparam int unsigned KW          = $clog2(BytesPerRow);

  localparam logic [KW-1:0]     LastByte = KW'(BytesPerRow - 1);
  localparam logic [ADDR_W-1:0] LastRow  = ADDR_W'(ROWS - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StWaitGrant} state_e;

  state_e            r_state_q, r_state_d;
  logic [ADDR_W-1:0] r_row_q, r_row_d;
  logic [KW-1:0]     r_k_q, r_k_d;
  logic [0:COLS-1]   r_buf_q, r_buf_d;
  logic              r_frame_done_q, r_frame_done_d;
  logic              r_err_q, r_err_d;

  logic              w_ready;
  logic              w_accept;
  logic              w_store;
  logic              w_wr_en;
  logic [KW-1:0]     w_idx;
  logic [0:COLS-1]   w_mask;
  logic [0:COLS-1]   w_wide;

  // Ready is forced low while reset is held, independent of state.
  assign w_ready  = i_rst && (r_state_q != StWaitGrant);
  assign w_accept = io_bus.in_valid && w_ready;

  always_comb begin
    r_state_d      = r_state_q;
    r_row_d        = r_row_q;
    r_k_d          = r_k_q;
    r_frame_done_d = 1'b0;
    r_err_d        = 1'b0;
    w_store        = 1'b0;
    w_idx          = r_k_q;
    w_wr_en        = 1'b0;
    unique case (r_state_q)
      StIdle: begin
        // Bytes without SOF are accepted and dropped.
        if (w_accept && io_bus.in_sof) begin
          w_store   = 1'b1;
          w_idx     = '0;
          r_row_d   = '0;
          r_k_d     = KW'(1);
          r_state_d = StCollect;
        end
      end
      StCollect: begin
        if (w_accept) begin
          w_store = 1'b1;
          if (io_bus.in_sof) begin
            // Restart the frame; rows already written stay in the buffer.
            r_err_d = (r_k_q != '0) || (r_row_q != '0);
            w_idx   = '0;
            r_row_d = '0;
            r_k_d   = KW'(1);
          end else if (r_k_q == LastByte) begin
            r_k_d     = '0;
            r_state_d = StWaitGrant;
          end else begin
            r_k_d = r_k_q + 1'b1;
          end
        end
      end
      StWaitGrant: begin
        // Only combinational output path: write strobe follows the grant.
        w_wr_en = io_bus.wr_grant && i_rst;
        if (io_bus.wr_grant) begin
          r_k_d = '0;
          if (r_row_q == LastRow) begin
            r_row_d        = '0;
            r_frame_done_d = 1'b1;
            r_state_d      = StIdle;
          end else begin
            r_row_d   = r_row_q + 1'b1;
            r_state_d = StCollect;
          end
        end
      end
      default: r_state_d = StIdle;
    endcase
  end

  // Byte k lands on cells 8k..8k+7, MSB first. Masks are built over the padded
  // byte width and shifted so the pad bits of the last byte fall off the end.
  assign w_mask = COLS'(({8'hFF, {(BufW - 8){1'b0}}} >> {w_idx, 3'b000}) >> (BufW - COLS));
  assign w_wide = COLS'({BytesPerRow{io_bus.in_data}} >> (BufW - COLS));

  always_comb begin
    r_buf_d = r_buf_q;
    if (w_store) begin
      r_buf_d = (r_buf_q & ~w_mask) | (w_wide & w_mask);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state_q      <= StIdle;
      r_row_q        <= '0;
      r_k_q          <= '0;
      r_buf_q        <= '0;
      r_frame_done_q <= 1'b0;
      r_err_q        <= 1'b0;
    end else begin
      r_state_q      <= r_state_d;
      r_row_q        <= r_row_d;
      r_k_q          <= r_k_d;
      r_buf_q        <= r_buf_d;
      r_frame_done_q <= r_frame_done_d;
      r_err_q        <= r_err_d;
    end
  end

  assign io_bus.in_ready = w_ready;
  assign io_bus.wr_en    = w_wr_en;
  assign io_bus.wr_addr  = r_row_q;
  assign io_bus.wr_data  = r_buf_q;
  assign o_busy          = (r_state_q != StIdle);
  assign o_frame_done    = r_frame_done_q;
  assign o_err           = r_err_q;

endmodule

// File: tb/tb_row_loader.sv
// tb_row_loader: randomized self-checking bench for row_loader. A transaction
// level model (byte queue per row) predicts ready, writes, pulses and busy.
module tb_row_loader;
  localparam int unsigned Rows  = 100;
  localparam int unsigned Cols  = 100;
  localparam int unsigned AddrW = 7;
  localparam int unsigned Bpr   = 13;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy, frame_done, err;

  row_loader_if #(.COLS(Cols), .ADDR_W(AddrW)) bus ();

  row_loader #(.ROWS(Rows), .COLS(Cols), .ADDR_W(AddrW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .io_bus       (bus),
    .o_busy       (busy),
    .o_frame_done (frame_done),
    .o_err        (err)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  bit              m_in_frame = 1'b0;
  bit              m_waiting  = 1'b0;
  bit              m_exp_fd   = 1'b0;
  bit              m_exp_err  = 1'b0;
  bit              m_rst_seen = 1'b0;
  int              m_row      = 0;
  logic [7:0]      m_bytes[$];
  logic [0:Cols-1] m_exp_data = '0;

  int grant_mode = 0;  // 0 always, 1 never, 2 toggle 10/10, 3 random
  int cyc        = 0;
  int n_writes   = 0;
  int n_fd       = 0;
  int n_err      = 0;

  function automatic logic [0:Cols-1] pack_row();
    logic [0:Cols-1] r;
    logic [7:0]      b;
    r = '0;
    for (int c = 0; c < Cols; c++) begin
      b = m_bytes[c / 8];
      r[7'(c)] = b[3'(7 - (c % 8))];
    end
    return r;
  endfunction

  // One clock cycle: drive at negedge, check, then advance the model over the edge.
  task automatic step(input logic rst_v, input logic v, input logic [7:0] d, input logic s,
                      output bit acc);
    logic g;
    logic exp_wr;
    @(negedge clk);
    rst          = rst_v;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_sof   = s;
    case (grant_mode)
      0:       g = 1'b1;
      1:       g = 1'b0;
      2:       g = ((cyc / 10) % 2) == 0;
      default: g = 1'($urandom_range(0, 1));
    endcase
    bus.wr_grant = g;
    cyc++;
    #1;
    exp_wr = rst_v && m_waiting && g;
    chk("in_ready", bus.in_ready, rst_v && !m_waiting);
    chk("wr_en", bus.wr_en, exp_wr);
    chk("busy", busy, m_in_frame);
    chk("frame_done", frame_done, m_exp_fd);
    chk("err", err, m_exp_err);
    if (exp_wr) begin
      chk("wr_addr", bus.wr_addr, m_row);
      chk("wr_data", bus.wr_data, m_exp_data);
    end
    if (!rst_v && m_rst_seen) begin
      chk("rst_wr_addr", bus.wr_addr, 0);
      chk("rst_wr_data", bus.wr_data, 0);
    end
    if (bus.wr_en) n_writes++;
    if (frame_done) n_fd++;
    if (err) n_err++;

    acc       = rst_v && !m_waiting && v;
    m_exp_fd  = 1'b0;
    m_exp_err = 1'b0;
    if (!rst_v) begin
      m_in_frame = 1'b0;
      m_waiting  = 1'b0;
      m_row      = 0;
      m_bytes.delete();
      m_rst_seen = 1'b1;
    end else begin
      m_rst_seen = 1'b0;
      if (m_waiting) begin
        if (g) begin
          m_waiting = 1'b0;
          m_bytes.delete();
          if (m_row == Rows - 1) begin
            m_in_frame = 1'b0;
            m_exp_fd   = 1'b1;
            m_row      = 0;
          end else begin
            m_row++;
          end
        end
      end else if (acc) begin
        if (s) begin
          if (m_in_frame && (m_bytes.size() != 0 || m_row != 0)) m_exp_err = 1'b1;
          m_in_frame = 1'b1;
          m_row      = 0;
          m_bytes.delete();
          m_bytes.push_back(d);
        end else if (m_in_frame) begin
          m_bytes.push_back(d);
        end
        if (m_bytes.size() == Bpr) begin
          m_waiting  = 1'b1;
          m_exp_data = pack_row();
        end
      end
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'($urandom), 1'($urandom), acc);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic s);
    bit acc;
    for (int i = 0; i < 2000; i++) begin
      step(1'b1, 1'b1, d, s, acc);
      if (acc) return;
    end
    chk("send_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    bit              acc;
    logic [0:Cols-1] k_exp;
    int              w0, f0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_sof   = 1'b0;
    bus.wr_grant = 1'b0;

    // Reset held with valid bytes offered
    repeat (3) step(1'b0, 1'b1, 8'($urandom), 1'b1, acc);
    idle(2);

    // Bytes without SOF in idle are dropped
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0);
    idle(3);

    // Single row, immediate grant
    send_byte(8'h80, 1'b1);
    for (int i = 0; i < 11; i++) send_byte(8'h00, 1'b0);
    send_byte(8'hF0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, acc);
    k_exp        = '0;
    k_exp[0]     = 1'b1;
    k_exp[96:99] = 4'hF;
    chk("single_row_en", bus.wr_en, 1'b1);
    chk("single_row_data", bus.wr_data, k_exp);

    // Grant stall on row 1
    grant_mode = 1;
    for (int i = 0; i < Bpr; i++) send_byte(8'($urandom), 1'b0);
    for (int i = 0; i < 50; i++) begin
      step(1'b1, 1'b1, 8'($urandom), 1'b0, acc);
      chk("stall_data", bus.wr_data, m_exp_data);
    end
    grant_mode = 0;
    idle(1);

    // Row 2 complete, 5 bytes of row 3, then a mid-frame SOF
    for (int i = 0; i < Bpr; i++) send_byte(8'($urandom), 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0);
    f0 = n_err;
    send_byte(8'($urandom), 1'b1);
    for (int i = 0; i < Bpr - 1; i++) send_byte(8'($urandom), 1'b0);
    idle(1);
    chk("err_pulses", n_err - f0, 1);

    // Full frame, row r filled with byte r, toggling grant
    grant_mode = 2;
    w0 = n_writes;
    f0 = n_fd;
    for (int r = 0; r < Rows; r++)
      for (int b = 0; b < Bpr; b++) send_byte(8'(r), (r == 0) && (b == 0));
    for (int i = 0; i < 40 && n_fd == f0; i++) idle(1);
    idle(1);
    chk("frame_writes", n_writes - w0, Rows);
    chk("frame_done_count", n_fd - f0, 1);
    chk("frame_busy_after", busy, 1'b0);

    // Randomized traffic
    grant_mode = 3;
    send_byte(8'($urandom), 1'b1);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else send_byte(8'($urandom), $urandom_range(0, 59) == 0);
    end
    grant_mode = 0;
    idle(2);

    // Reset while waiting for a grant
    grant_mode = 1;
    send_byte(8'($urandom), 1'b1);
    for (int i = 0; i < Bpr - 1; i++) send_byte(8'($urandom), 1'b0);
    idle(3);
    grant_mode = 0;
    w0 = n_writes;
    repeat (2) step(1'b0, 1'b0, 8'h00, 1'b0, acc);
    chk("reset_no_write", n_writes - w0, 0);
    idle(1);
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < Bpr - 1; i++) send_byte(8'($urandom), 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, acc);
    chk("post_reset_wr_en", bus.wr_en, 1'b1);
    chk("post_reset_addr", bus.wr_addr, 0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
